// File: rtl/friscv_pkg.sv
// Shared types for the execute-stage multiply/divide unit.
// The op encoding equals funct3 of the RV32M instructions.
package friscv_pkg;

    localparam int ARCH = 32;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_t;

    function automatic logic is_signed_a(md_op_t op);
        case (op)
            MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_b(md_op_t op);
        case (op)
            MD_MUL, MD_MULH, MD_DIV, MD_REM: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Two-lane conditional two's-complement negation: operands to magnitudes
// on the way in, magnitudes back to signed results on the way out.
module md_sign_fix #(
    parameter int XW = 32,
    parameter int YW = 32
) (
    input  logic [XW-1:0] x_in,
    input  logic          x_neg,
    input  logic [YW-1:0] y_in,
    input  logic          y_neg,
    output logic [XW-1:0] x_out,
    output logic [YW-1:0] y_out
);

    assign x_out = x_neg ? (~x_in + {{(XW-1){1'b0}}, 1'b1}) : x_in;
    assign y_out = y_neg ? (~y_in + {{(YW-1){1'b0}}, 1'b1}) : y_in;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on magnitudes, one bit per cycle, sign applied at the end.
module muldiv_unit
    import friscv_pkg::*;
#(
    parameter int WIDTH = ARCH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  md_op_t           op_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] result_out
);

    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

    md_state_t          state_r, next_state_s;
    md_op_t             op_r;
    logic [2*WIDTH-1:0] prod_r, nxt_prod_s, fix_x_in_s, fix_prod_s;
    logic [WIDTH-1:0]   rem_r, nxt_rem_s, div_r, result_r;
    logic [WIDTH-1:0]   mag_a_s, mag_b_s, special_res_s, final_res_s, fix_rem_s;
    logic [WIDTH-1:0]   div_diff_s;
    logic [WIDTH:0]     mul_sum_s, div_shift_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               sa_r, sb_r, valid_r, ready_r;
    logic               accept_s, special_s, neg_a_s, neg_b_s, last_iter_s, div_ge_s;

    assign ready_out  = ready_r;
    assign valid_out  = valid_r;
    assign result_out = result_r;

    assign accept_s    = valid_in && ready_r && (state_r == IDLE) && !flush_in;
    assign last_iter_s = (cnt_r == CNT_ONE);
    assign neg_a_s     = is_signed_a(op_in) && a_in[WIDTH-1];
    assign neg_b_s     = is_signed_b(op_in) && b_in[WIDTH-1];
    // Divide by zero, or MIN / -1 for the signed divides (op[0]==0)
    assign special_s   = op_in[2] && ((b_in == ZERO) ||
                         (!op_in[0] && (a_in == MIN_VAL) && (b_in == ONES)));

    md_sign_fix #(.XW(WIDTH), .YW(WIDTH)) u_in_fix (
        .x_in  (a_in),
        .x_neg (neg_a_s),
        .y_in  (b_in),
        .y_neg (neg_b_s),
        .x_out (mag_a_s),
        .y_out (mag_b_s)
    );

    // Architectural results for the divide corner cases, decided at accept
    always_comb begin
        special_res_s = ZERO;
        if (b_in == ZERO) begin
            if (op_in[1]) special_res_s = a_in;
            else          special_res_s = ONES;
        end else begin
            if (op_in[1]) special_res_s = ZERO;
            else          special_res_s = MIN_VAL;
        end
    end

    assign mul_sum_s   = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, div_r};
    assign div_shift_s = {rem_r, prod_r[WIDTH-1]};
    assign div_ge_s    = (div_shift_s >= {1'b0, div_r});
    assign div_diff_s  = div_shift_s[WIDTH-1:0] - div_r;

    // One iteration: the low half of prod_r holds the multiplier or the dividend/quotient
    always_comb begin
        nxt_prod_s = prod_r;
        nxt_rem_s  = rem_r;
        if (op_r[2]) begin
            nxt_prod_s = {prod_r[2*WIDTH-1:WIDTH], prod_r[WIDTH-2:0], div_ge_s};
            if (div_ge_s) nxt_rem_s = div_diff_s;
            else          nxt_rem_s = div_shift_s[WIDTH-1:0];
        end else if (prod_r[0]) begin
            nxt_prod_s = {mul_sum_s, prod_r[WIDTH-1:1]};
        end else begin
            nxt_prod_s = {1'b0, prod_r[2*WIDTH-1:1]};
        end
    end

    assign fix_x_in_s = op_r[2] ? {ZERO, nxt_prod_s[WIDTH-1:0]} : nxt_prod_s;

    md_sign_fix #(.XW(2*WIDTH), .YW(WIDTH)) u_out_fix (
        .x_in  (fix_x_in_s),
        .x_neg (sa_r ^ sb_r),
        .y_in  (nxt_rem_s),
        .y_neg (sa_r),
        .x_out (fix_prod_s),
        .y_out (fix_rem_s)
    );

    // Pick the result field for the operation in flight
    always_comb begin
        final_res_s = fix_prod_s[WIDTH-1:0];
        case (op_r)
            MD_MULH, MD_MULHSU, MD_MULHU: final_res_s = fix_prod_s[2*WIDTH-1:WIDTH];
            MD_REM, MD_REMU:              final_res_s = fix_rem_s;
            default:                      final_res_s = fix_prod_s[WIDTH-1:0];
        endcase
    end

    // Next-state logic; flush overrides accept and handoff
    always_comb begin
        next_state_s = state_r;
        if (flush_in) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) next_state_s = special_s ? DONE : BUSY;
                    else          next_state_s = IDLE;
                end
                BUSY: begin
                    if (last_iter_s) next_state_s = DONE;
                    else             next_state_s = BUSY;
                end
                DONE: begin
                    if (ready_in) next_state_s = IDLE;
                    else          next_state_s = DONE;
                end
                default: next_state_s = IDLE;
            endcase
        end
    end

    // State and handshake registers; ready waits one idle cycle after a handoff
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            valid_r <= (next_state_s == DONE);
            ready_r <= (state_r == IDLE) && (next_state_s == IDLE);
        end
    end

    // Operand capture, iteration datapath and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r   <= {2*WIDTH{1'b0}};
            rem_r    <= ZERO;
            div_r    <= ZERO;
            op_r     <= MD_MUL;
            sa_r     <= 1'b0;
            sb_r     <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            result_r <= ZERO;
        end else if (accept_s) begin
            prod_r <= {ZERO, mag_a_s};
            rem_r  <= ZERO;
            div_r  <= mag_b_s;
            op_r   <= op_in;
            sa_r   <= neg_a_s;
            sb_r   <= neg_b_s;
            cnt_r  <= CNT_INIT;
            if (special_s) result_r <= special_res_s;
        end else if ((state_r == BUSY) && !flush_in) begin
            prod_r <= nxt_prod_s;
            rem_r  <= nxt_rem_s;
            cnt_r  <= cnt_r - CNT_ONE;
            if (last_iter_s) result_r <= final_res_s;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: an arithmetic reference model, a per-cycle
// output monitor and hand-computed expectations for the RV32M corner cases.
module tb_muldiv_unit;
    import friscv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush_in = 1'b0;
    logic         valid_in = 1'b0;
    logic         ready_in = 1'b0;
    md_op_t       op_in = MD_MUL;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         ready_out, valid_out;
    logic [W-1:0] result_out;

    int           errors = 0;
    int           checks = 0;
    bit           pending = 1'b0;
    logic [W-1:0] exp_res = '0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_in   (flush_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .op_in      (op_in),
        .a_in       (a_in),
        .b_in       (b_in),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .result_out (result_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: plain 64-bit arithmetic plus the RISC-V divide rules
    function automatic logic [31:0] model(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0] up;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            MD_MULH:   begin sp = sa * sb; return sp[63:32]; end
            MD_MULHSU: begin sp = sa * $signed({32'd0, b}); return sp[63:32]; end
            MD_MULHU:  begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            MD_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                sp = sa / sb;
                return sp[31:0];
            end
            MD_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                sp = sa % sb;
                return sp[31:0];
            end
            MD_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            MD_REMU: return (b == 32'd0) ? a : a % b;
            default: begin sp = sa * sb; return sp[31:0]; end
        endcase
    endfunction

    // Monitor: any valid_out must belong to an outstanding op and carry the model result
    always @(negedge clk) begin
        if (rst_n && valid_out) begin
            chk("valid_expected", {63'd0, pending}, 64'd1);
            if (pending) chk("result_stream", {32'd0, result_out}, {32'd0, exp_res});
        end
        if (rst_n && pending) chk("ready_low_busy", {63'd0, ready_out}, 64'd0);
    end

    task automatic do_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lit, input int stall);
        int n;
        int lat;
        logic [2:0] oc;
        logic [31:0] held;
        n = 0;
        while (!ready_out && n < 100) begin @(negedge clk); n++; end
        chk("ready_before_accept", {63'd0, ready_out}, 64'd1);
        exp_res = model(op, a, b);
        chk($sformatf("model_%s", op.name()), {32'd0, exp_res}, {32'd0, lit});
        oc = op;
        lat = (oc[2] && (b == 32'd0 || (!oc[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : W + 1;
        valid_in = 1'b1; op_in = op; a_in = a; b_in = b; ready_in = 1'b0;
        @(posedge clk); #1;
        valid_in = 1'b0;
        pending = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!valid_out && n < 100);
        chk($sformatf("latency_%s", op.name()), 64'(n), 64'(lat));
        chk($sformatf("result_%s", op.name()), {32'd0, result_out}, {32'd0, lit});
        held = result_out;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", {63'd0, valid_out}, 64'd1);
            chk("stall_stable", {32'd0, result_out}, {32'd0, held});
        end
        ready_in = 1'b1;
        @(posedge clk); #1;
        pending = 1'b0;
        ready_in = 1'b0;
        @(negedge clk);
        chk("valid_drop", {63'd0, valid_out}, 64'd0);
        chk("ready_lag", {63'd0, ready_out}, 64'd0);
        @(negedge clk);
        chk("ready_back", {63'd0, ready_out}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        repeat (3) @(negedge clk);
        chk("reset_ready", {63'd0, ready_out}, 64'd0);
        chk("reset_valid", {63'd0, valid_out}, 64'd0);
        chk("reset_result", {32'd0, result_out}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", {63'd0, ready_out}, 64'd1);
        @(negedge clk);

        do_op(MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        do_op(MD_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 0);
        do_op(MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        do_op(MD_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 0);
        do_op(MD_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0);
        do_op(MD_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 0);
        do_op(MD_DIVU,   32'd100,        32'd7,         32'd14,        0);
        do_op(MD_REMU,   32'd100,        32'd7,         32'd2,         10);
        do_op(MD_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 0);
        do_op(MD_REM,    32'd5,          32'd0,         32'd5,         10);
        do_op(MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
        do_op(MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0);
        do_op(MD_DIVU,   32'd7,          32'd0,         32'hFFFF_FFFF, 0);
        do_op(MD_REMU,   32'd7,          32'd0,         32'd7,         0);

        // Flush a DIV in its twelfth cycle: no result may ever appear
        valid_in = 1'b1; op_in = MD_DIV; a_in = 32'd1000; b_in = 32'd7;
        @(posedge clk); #1;
        valid_in = 1'b0;
        pending = 1'b1;
        repeat (12) @(negedge clk);
        flush_in = 1'b1;
        @(posedge clk); #1;
        flush_in = 1'b0;
        pending = 1'b0;
        @(negedge clk);
        chk("flush_valid", {63'd0, valid_out}, 64'd0);
        chk("flush_ready_lag", {63'd0, ready_out}, 64'd0);
        @(negedge clk);
        chk("flush_ready_back", {63'd0, ready_out}, 64'd1);
        seen = 0;
        repeat (40) begin @(negedge clk); if (valid_out) seen++; end
        chk("flush_no_valid", 64'(seen), 64'd0);
        do_op(MD_DIVU, 32'd9, 32'd3, 32'd3, 0);

        // Asynchronous reset in cycle 5 of a MUL
        valid_in = 1'b1; op_in = MD_MUL; a_in = 32'd7; b_in = 32'hFFFF_FFFD;
        @(posedge clk); #1;
        valid_in = 1'b0;
        pending = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        pending = 1'b0;
        #1;
        chk("async_rst_valid", {63'd0, valid_out}, 64'd0);
        chk("async_rst_ready", {63'd0, ready_out}, 64'd0);
        chk("async_rst_result", {32'd0, result_out}, 64'd0);
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_release", {63'd0, ready_out}, 64'd1);
        seen = 0;
        repeat (40) begin @(negedge clk); if (valid_out) seen++; end
        chk("rst_no_valid", 64'(seen), 64'd0);
        do_op(MD_MULHU, 32'd2, 32'd3, 32'd0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
